// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement engine: direction codes, FSM states
// and direction helpers.
package snake_pkg;

  localparam int DIR_W = 5;

  // One-hot direction codes {stop, up, left, down, right}
  localparam logic [DIR_W-1:0] DIR_RIGHT = 5'b00001;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 5'b00010;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 5'b00100;
  localparam logic [DIR_W-1:0] DIR_UP    = 5'b01000;
  localparam logic [DIR_W-1:0] DIR_STOP  = 5'b10000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    OVER
  } state_e;

  function automatic logic is_opposite(input logic [DIR_W-1:0] a,
                                       input logic [DIR_W-1:0] b);
    return ((a == DIR_RIGHT) && (b == DIR_LEFT))  ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP));
  endfunction

  function automatic logic is_move(input logic [DIR_W-1:0] d);
    return (d == DIR_RIGHT) || (d == DIR_DOWN) || (d == DIR_LEFT) || (d == DIR_UP);
  endfunction

endpackage

// File: rtl/snake_if.sv
// Control/position bundle between the direction decoder, the snake engine and
// the draw/food logic.
interface snake_if #(
  parameter int GRID_W  = 128,
  parameter int GRID_H  = 64,
  parameter int MAX_LEN = 16
);
  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [4:0]             direction;
  logic                   grow;
  logic                   restart;
  logic [X_W-1:0]         head_x;
  logic [Y_W-1:0]         head_y;
  logic [MAX_LEN*X_W-1:0] tail_x;
  logic [MAX_LEN*Y_W-1:0] tail_y;
  logic [LEN_W-1:0]       length;
  logic                   step;
  logic                   game_over;

  modport master (
    output direction, grow, restart,
    input  head_x, head_y, tail_x, tail_y, length, step, game_over
  );

  modport slave (
    input  direction, grow, restart,
    output head_x, head_y, tail_x, tail_y, length, step, game_over
  );

endinterface

// File: rtl/snake_tick.sv
// Free-running 0..TICK-1 step timer with synchronous clear and freeze enable.
module snake_tick #(
  parameter int TICK = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CNT_W = $clog2(TICK);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(TICK - 1));

  // Next count: clear wins, otherwise count and wrap while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_engine.sv
// Snake movement engine: head plus variable-length tail, stepped once per TICK
// cycles, with reversal filtering, growth, wall/self collision and optional wrap.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W  = 128,
  parameter int GRID_H  = 64,
  parameter int MAX_LEN = 16,
  parameter int TICK    = 15165696,
  parameter int WRAP    = 0,
  parameter int INIT_X  = 50,
  parameter int INIT_Y  = 24
) (
  input  logic    clk,
  input  logic    reset_n,
  snake_if.slave  bus
);
  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  state_e           state_q, state_d;
  logic [4:0]       cur_dir_q, cur_dir_d;
  logic [LEN_W-1:0] pend_q, pend_d, pend_sum;
  logic [LEN_W-1:0] len_q, len_d, new_len, hit_lim;
  logic [X_W-1:0]   head_x_q, head_x_d, nh_x;
  logic [Y_W-1:0]   head_y_q, head_y_d, nh_y;
  logic [X_W-1:0]   tail_x_q [MAX_LEN];
  logic [X_W-1:0]   tail_x_d [MAX_LEN];
  logic [Y_W-1:0]   tail_y_q [MAX_LEN];
  logic [Y_W-1:0]   tail_y_d [MAX_LEN];
  logic             step_q, step_d, over_q, over_d;
  logic             tick, dir_ok, grow_now, wall, hit;
  logic [MAX_LEN-1:0] seg_hit;
  int               nx, ny;

  // Reset asserts immediately, releases two clocks after reset_n rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  snake_tick #(.TICK(TICK)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (bus.restart),
    .en_i   (state_q != OVER),
    .tick_o (tick)
  );

  assign dir_ok   = is_move(bus.direction) &&
                    !((len_q != '0) && is_opposite(bus.direction, cur_dir_q));
  assign pend_sum = (pend_q == '1) ? pend_q : pend_q + LEN_W'(bus.grow);
  assign grow_now = (pend_sum != '0) && (len_q < LEN_W'(MAX_LEN));
  assign new_len  = grow_now ? len_q + 1'b1 : len_q;
  // When not growing the last segment moves away this step, so it cannot be hit
  assign hit_lim  = grow_now ? len_q : ((len_q == '0) ? '0 : len_q - 1'b1);

  // Candidate head position with edge wrap or wall detection
  always_comb begin
    nx   = int'(head_x_q);
    ny   = int'(head_y_q);
    wall = 1'b0;
    case (cur_dir_q)
      DIR_RIGHT: nx = nx + 1;
      DIR_LEFT:  nx = nx - 1;
      DIR_DOWN:  ny = ny + 1;
      DIR_UP:    ny = ny - 1;
      default:   ;
    endcase
    if (nx < 0) begin
      if (WRAP != 0) nx = GRID_W - 1; else wall = 1'b1;
    end else if (nx >= GRID_W) begin
      if (WRAP != 0) nx = 0; else wall = 1'b1;
    end
    if (ny < 0) begin
      if (WRAP != 0) ny = GRID_H - 1; else wall = 1'b1;
    end else if (ny >= GRID_H) begin
      if (WRAP != 0) ny = 0; else wall = 1'b1;
    end
  end
  assign nh_x = X_W'(nx);
  assign nh_y = Y_W'(ny);

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    assign seg_hit[i] = (tail_x_q[i] == nh_x) && (tail_y_q[i] == nh_y) &&
                        (LEN_W'(i) < hit_lim);
    assign bus.tail_x[i*X_W +: X_W] = tail_x_q[i];
    assign bus.tail_y[i*Y_W +: Y_W] = tail_y_q[i];
  end
  assign hit = wall || (|seg_hit);

  // Next-state, direction filter, growth and move step
  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    pend_d    = pend_q;
    len_d     = len_q;
    head_x_d  = head_x_q;
    head_y_d  = head_y_q;
    tail_x_d  = tail_x_q;
    tail_y_d  = tail_y_q;
    step_d    = 1'b0;
    over_d    = over_q;
    if (bus.restart) begin
      state_d   = IDLE;
      cur_dir_d = DIR_STOP;
      pend_d    = '0;
      len_d     = '0;
      head_x_d  = X_W'(INIT_X);
      head_y_d  = Y_W'(INIT_Y);
      tail_x_d  = '{default: '0};
      tail_y_d  = '{default: '0};
      over_d    = 1'b0;
    end else if (state_q != OVER) begin
      if (dir_ok) cur_dir_d = bus.direction;
      pend_d = pend_sum;
      case (state_q)
        IDLE, PAUSE: if (dir_ok) state_d = RUN;
        RUN: begin
          if (tick && hit) begin
            over_d  = 1'b1;
            state_d = OVER;
          end else begin
            if (tick) begin
              step_d      = 1'b1;
              len_d       = new_len;
              pend_d      = grow_now ? pend_sum - 1'b1 : pend_sum;
              head_x_d    = nh_x;
              head_y_d    = nh_y;
              tail_x_d[0] = head_x_q;
              tail_y_d[0] = head_y_q;
              for (int unsigned i = 1; i < MAX_LEN; i++) begin
                tail_x_d[i] = tail_x_q[i-1];
                tail_y_d[i] = tail_y_q[i-1];
              end
              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (i >= 32'(new_len)) begin
                  tail_x_d[i] = '0;
                  tail_y_d[i] = '0;
                end
              end
            end
            if (bus.direction == DIR_STOP) state_d = PAUSE;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_dir_q <= DIR_STOP;
      pend_q    <= '0;
      len_q     <= '0;
      head_x_q  <= X_W'(INIT_X);
      head_y_q  <= Y_W'(INIT_Y);
      tail_x_q  <= '{default: '0};
      tail_y_q  <= '{default: '0};
      step_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_dir_q <= cur_dir_d;
      pend_q    <= pend_d;
      len_q     <= len_d;
      head_x_q  <= head_x_d;
      head_y_q  <= head_y_d;
      tail_x_q  <= tail_x_d;
      tail_y_q  <= tail_y_d;
      step_q    <= step_d;
      over_q    <= over_d;
    end
  end

  assign bus.head_x    = head_x_q;
  assign bus.head_y    = head_y_q;
  assign bus.length    = len_q;
  assign bus.step      = step_q;
  assign bus.game_over = over_q;

endmodule
